// File: rtl/mac_array_drain_pkg.sv
// Shared definitions for the MAC array drain block.
// Holds the default geometry, the derived beat count / beat counter width,
// and the drain FSM state type used by the top level.
package mac_array_drain_pkg;

    localparam int unsigned NUM_MACS_DEF   = 16;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PACK_DEF       = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 16;

    localparam int unsigned NUM_BEATS_DEF  = NUM_MACS_DEF / PACK_DEF;

    // A single-beat configuration still needs a 1-bit counter to stay legal.
    function automatic int unsigned beat_cnt_width(input int unsigned n_beats);
        return (n_beats > 1) ? $clog2(n_beats) : 1;
    endfunction

    localparam int unsigned BEAT_CNT_WIDTH_DEF = beat_cnt_width(NUM_BEATS_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/mac_array_drain_beat_select.sv
// drain_beat_select: combinational beat mux for the drain path.
// Picks lanes [k*PACK .. k*PACK+PACK-1] from the snapshot (lowest lane in
// the LSBs of the beat) and clamps negative lanes to zero when ReLU is on.
//   i_snapshot  NUM_MACS*DATA_WIDTH  captured lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_k         CNT_W                beat index
//   i_relu_en   1                    clamp lanes with MSB set to 0
//   o_beat      PACK*DATA_WIDTH      selected, clamped beat
module drain_beat_select
    import mac_array_drain_pkg::*;
#(
    parameter int unsigned NUM_MACS   = NUM_MACS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    parameter int unsigned CNT_W      = BEAT_CNT_WIDTH_DEF
) (
    input  logic [NUM_MACS*DATA_WIDTH-1:0] i_snapshot,
    input  logic [CNT_W-1:0]               i_k,
    input  logic                           i_relu_en,
    output logic [PACK*DATA_WIDTH-1:0]     o_beat
);

    logic [DATA_WIDTH-1:0] w_lane;
    int unsigned           w_idx;

    always_comb begin
        o_beat = '0;
        w_lane = '0;
        w_idx  = 0;
        for (int unsigned j = 0; j < PACK; j++) begin
            w_idx  = (32'(i_k) * PACK + j) * DATA_WIDTH;
            w_lane = i_snapshot[w_idx +: DATA_WIDTH];
            if (i_relu_en && w_lane[DATA_WIDTH-1]) begin
                w_lane = '0;
            end
            o_beat[j*DATA_WIDTH +: DATA_WIDTH] = w_lane;
        end
    end

endmodule

// File: rtl/mac_array_drain.sv
// mac_array_drain: snapshots all MAC lane results in one cycle, optionally
// applies ReLU, and streams them as packed beats over valid/ready so the MAC
// array can start its next accumulation while the drain runs.
//   clk, arst_n_in         clock / synchronous active-low reset
//   capture, capture_ready snapshot request and acceptance
//   mac_out                NUM_MACS signed lanes
//   relu_en, base_addr     sampled at an accepted capture
//   out_valid/out_ready    beat handshake; out_data, out_addr, out_last payload
//   done                   one-cycle pulse after the final beat handshake
//   overrun                one-cycle pulse for a capture that was not accepted
module mac_array_drain
    import mac_array_drain_pkg::*;
#(
    parameter int unsigned NUM_MACS   = NUM_MACS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic                           capture,
    output logic                           capture_ready,
    input  logic [NUM_MACS*DATA_WIDTH-1:0] mac_out,
    input  logic                           relu_en,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PACK*DATA_WIDTH-1:0]     out_data,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic                           out_last,
    output logic                           done,
    output logic                           overrun
);

    localparam int unsigned     NUM_BEATS = NUM_MACS / PACK;
    localparam int unsigned     CNT_W     = beat_cnt_width(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(NUM_BEATS - 1);

    drain_state_t                   r_state;
    drain_state_t                   w_state_nxt;
    logic [NUM_MACS*DATA_WIDTH-1:0] r_snap;
    logic                           r_relu;
    logic [ADDR_WIDTH-1:0]          r_base;
    logic [CNT_W-1:0]               r_k;
    logic                           r_done;
    logic                           r_overrun;

    logic                           w_last_k;
    logic                           w_hs;
    logic                           w_final;
    logic                           w_accept;
    logic [PACK*DATA_WIDTH-1:0]     w_beat;

    assign w_last_k = (r_k == LAST_K);
    assign w_hs     = out_valid && out_ready;
    assign w_final  = w_hs && w_last_k;
    assign w_accept = capture && capture_ready;

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // capture_ready opens during DRAIN only in the cycle of the final
    // handshake, which lets a new snapshot follow with no idle beat.
    always_comb begin
        w_state_nxt   = r_state;
        out_valid     = 1'b0;
        capture_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                capture_ready = 1'b1;
                if (capture) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_last_k) begin
                    capture_ready = 1'b1;
                    w_state_nxt   = capture ? DRAIN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_snap    <= '0;
            r_relu    <= 1'b0;
            r_base    <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_final;
            r_overrun <= capture && !capture_ready;
            if (w_accept) begin
                r_snap <= mac_out;
                r_relu <= relu_en;
                r_base <= base_addr;
                r_k    <= '0;
            end else if (w_final) begin
                r_k <= '0;
            end else if (w_hs) begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    drain_beat_select #(
        .NUM_MACS   (NUM_MACS),
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK),
        .CNT_W      (CNT_W)
    ) u_beat_select (
        .i_snapshot (r_snap),
        .i_k        (r_k),
        .i_relu_en  (r_relu),
        .o_beat     (w_beat)
    );

    assign out_data = out_valid ? w_beat : '0;
    assign out_addr = out_valid ? (r_base + ADDR_WIDTH'(r_k)) : '0;
    assign out_last = out_valid && w_last_k;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule
